axi_stream_extract_header: RTL and testbench

Strips a per-packet header of 0..DATA_BYTE_WD bytes from the front of an AXI-Stream packet. Emits the header as a single beat on a header channel, and re-aligns the remaining payload so its first byte lands in the MSB lane. It is the receive-side counterpart of the header-insertion block: an inserted header of N bytes, stripped with byte_extract_cnt = N, recovers the original header beat and payload bit-exactly.

---
 rtl/axi_stream_extract_header_if.sv | 37 +++
 rtl/axi_stream_extract_header.sv | 126 ++++++++++++
 tb/tb_axi_stream_extract_header.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_extract_header_if.sv
// Handshake bundle for the header extractor: input stream, payload stream and header channel.
interface axi_stream_extract_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;
  logic [BYTE_CNT_WD:0]    byte_extract_cnt;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_header;
  logic [DATA_WD-1:0]      header_out;
  logic [DATA_BYTE_WD-1:0] keep_header;
  logic                    ready_header;
  logic                    short_pkt;

  modport slave (
    input  valid_in, data_in, keep_in, last_in, byte_extract_cnt, ready_out, ready_header,
    output ready_in, valid_out, data_out, keep_out, last_out,
           valid_header, header_out, keep_header, short_pkt
  );

  modport master (
    output valid_in, data_in, keep_in, last_in, byte_extract_cnt, ready_out, ready_header,
    input  ready_in, valid_out, data_out, keep_out, last_out,
           valid_header, header_out, keep_header, short_pkt
  );
endinterface

// File: rtl/axi_stream_extract_header.sv
// Strips an N-byte header off each AXI-Stream packet and re-aligns the payload to the MSB lane.
// state   | meaning
// S_HDR   | waiting for first beat; captures header and initial residue
// S_BODY  | splicing residue with the top N bytes of each following beat
// S_FLUSH | emitting the trailing residue as the final payload beat
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input logic clk,
  input logic rst,
  axi_stream_extract_header_if.slave bus
);
  localparam logic [BYTE_CNT_WD:0] W_CNT = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);

  typedef enum logic [1:0] {S_HDR, S_BODY, S_FLUSH} state_t;

  state_t                  state;
  logic [BYTE_CNT_WD:0]    n_q, rc_q;
  logic [DATA_WD-1:0]      res_q;
  logic                    valid_out_q, last_out_q, valid_header_q, short_pkt_q;
  logic [DATA_WD-1:0]      data_out_q, header_q;
  logic [DATA_BYTE_WD-1:0] keep_out_q, keep_header_q;

  logic [BYTE_CNT_WD:0]    n_in, n_cur, k_in, rc_next, k_min, body_cnt;
  logic [BYTE_CNT_WD+3:0]  sh_n, sh_wn;
  logic [DATA_WD-1:0]      keep_bits, data_m;
  logic                    ready_in_c, in_fire;

  function automatic logic [BYTE_CNT_WD:0] ones(input logic [DATA_BYTE_WD-1:0] v);
    ones = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) ones = ones + {{BYTE_CNT_WD{1'b0}}, v[i]};
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] lmask(input logic [BYTE_CNT_WD:0] c);
    lmask = ~({DATA_BYTE_WD{1'b1}} >> c);
  endfunction

  always_comb begin
    n_in     = (bus.byte_extract_cnt > W_CNT) ? W_CNT : bus.byte_extract_cnt;
    n_cur    = (state == S_HDR) ? n_in : n_q;
    k_in     = ones(bus.keep_in);
    rc_next  = (k_in > n_cur) ? k_in - n_cur : '0;
    k_min    = (k_in < n_cur) ? k_in : n_cur;
    body_cnt = (W_CNT - n_cur) + k_min;
    sh_n     = {n_cur, 3'b000};
    sh_wn    = {W_CNT - n_cur, 3'b000};
    keep_bits = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) keep_bits[8*i +: 8] = {8{bus.keep_in[i]}};
    // bytes outside keep are forced to zero so padding never leaks into header or payload
    data_m = bus.data_in & keep_bits;
    case (state)
      S_HDR:   ready_in_c = !valid_header_q || bus.ready_header;
      S_BODY:  ready_in_c = !valid_out_q || bus.ready_out;
      default: ready_in_c = 1'b0;
    endcase
    in_fire = bus.valid_in && ready_in_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_HDR;
      n_q            <= '0;
      rc_q           <= '0;
      res_q          <= '0;
      valid_out_q    <= 1'b0;
      data_out_q     <= '0;
      keep_out_q     <= '0;
      last_out_q     <= 1'b0;
      valid_header_q <= 1'b0;
      header_q       <= '0;
      keep_header_q  <= '0;
      short_pkt_q    <= 1'b0;
    end else begin
      short_pkt_q <= 1'b0;
      if (valid_header_q && bus.ready_header) valid_header_q <= 1'b0;
      if (valid_out_q && bus.ready_out) valid_out_q <= 1'b0;
      case (state)
        S_HDR: if (in_fire) begin
          n_q            <= n_in;
          header_q       <= data_m >> sh_wn;
          keep_header_q  <= bus.keep_in >> (W_CNT - n_in);
          valid_header_q <= 1'b1;
          res_q          <= data_m << sh_n;
          rc_q           <= rc_next;
          if (!bus.last_in)   state <= S_BODY;
          else if (k_in > n_in) state <= S_FLUSH;
          else if (k_in < n_in) short_pkt_q <= 1'b1;
        end
        S_BODY: if (in_fire) begin
          valid_out_q <= 1'b1;
          data_out_q  <= res_q | (data_m >> sh_wn);
          keep_out_q  <= lmask(body_cnt);
          res_q       <= data_m << sh_n;
          rc_q        <= rc_next;
          last_out_q  <= 1'b0;
          if (bus.last_in) begin
            if (rc_next != '0) state <= S_FLUSH;
            else begin
              last_out_q <= 1'b1;
              state      <= S_HDR;
            end
          end
        end
        default: if (!valid_out_q || bus.ready_out) begin
          valid_out_q <= 1'b1;
          data_out_q  <= res_q;
          keep_out_q  <= lmask(rc_q);
          last_out_q  <= 1'b1;
          state       <= S_HDR;
        end
      endcase
    end
  end

  assign bus.ready_in     = ready_in_c;
  assign bus.valid_out    = valid_out_q;
  assign bus.data_out     = data_out_q;
  assign bus.keep_out     = keep_out_q;
  assign bus.last_out     = last_out_q;
  assign bus.valid_header = valid_header_q;
  assign bus.header_out   = header_q;
  assign bus.keep_header  = keep_header_q;
  assign bus.short_pkt    = short_pkt_q;
endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed and random-stall bench for axi_stream_extract_header with a byte-level round-trip model.
module tb_axi_stream_extract_header;
  logic clk, rst;
  axi_stream_extract_header_if bus();
  axi_stream_extract_header dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_pass = 0;
  int short_cnt = 0, hold_err = 0;
  bit rnd_on = 0;
  logic [35:0] exp_hdr[$], act_hdr[$];
  logic [36:0] exp_pay[$], act_pay[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic ready_gen();
    bus.ready_out = 1'b1;
    bus.ready_header = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rnd_on) begin
        bus.ready_out    = ($urandom_range(0, 2) != 0);
        bus.ready_header = ($urandom_range(0, 2) != 0);
      end else begin
        bus.ready_out    = 1'b1;
        bus.ready_header = 1'b1;
      end
    end
  endtask

  task automatic monitor();
    bit ph = 0, pp = 0;
    logic [35:0] hs;
    logic [36:0] ps;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = 0; pp = 0;
      end else begin
        if (ph && !(bus.valid_header && {bus.keep_header, bus.header_out} == hs)) hold_err++;
        if (pp && !(bus.valid_out && {bus.last_out, bus.keep_out, bus.data_out} == ps)) hold_err++;
        ph = bus.valid_header && !bus.ready_header;
        pp = bus.valid_out && !bus.ready_out;
        hs = {bus.keep_header, bus.header_out};
        ps = {bus.last_out, bus.keep_out, bus.data_out};
        if (bus.valid_header && bus.ready_header) act_hdr.push_back(hs);
        if (bus.valid_out && bus.ready_out) act_pay.push_back(ps);
        if (bus.short_pkt) short_cnt++;
      end
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                      input logic [2:0] n, output int waits);
    bus.valid_in = 1'b1; bus.data_in = d; bus.keep_in = k; bus.last_in = l;
    bus.byte_extract_cnt = n;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.ready_in) break;
      if (waits >= 500) begin
        chk("in_timeout", {63'd0, bus.ready_in}, 64'd1);
        break;
      end
      waits++;
    end
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.last_in = 1'b0;
  endtask

  task automatic settle_and_compare(input string tag);
    int m;
    repeat (20) @(posedge clk);
    #1;
    chk({tag, "_hdr_n"}, act_hdr.size(), exp_hdr.size());
    m = (act_hdr.size() < exp_hdr.size()) ? act_hdr.size() : exp_hdr.size();
    for (int i = 0; i < m; i++) chk({tag, "_hdr"}, act_hdr[i], exp_hdr[i]);
    chk({tag, "_pay_n"}, act_pay.size(), exp_pay.size());
    m = (act_pay.size() < exp_pay.size()) ? act_pay.size() : exp_pay.size();
    for (int i = 0; i < m; i++) chk({tag, "_pay"}, act_pay[i], exp_pay[i]);
    act_hdr.delete(); exp_hdr.delete(); act_pay.delete(); exp_pay.delete();
  endtask

  task automatic run_t1(input string tag);
    int w;
    exp_hdr.push_back({4'b0011, 32'h00001122});
    exp_pay.push_back({1'b0, 4'b1111, 32'h33445566});
    exp_pay.push_back({1'b1, 4'b1111, 32'h778899AA});
    send(32'h11223344, 4'b1111, 1'b0, 3'd2, w);
    chk({tag, "_hdr_lat"}, {63'd0, bus.valid_header}, 64'd1);
    chk({tag, "_no_pay_first"}, {63'd0, bus.valid_out}, 64'd0);
    send(32'h55667788, 4'b1111, 1'b0, 3'd2, w);
    chk({tag, "_pay_lat"}, {63'd0, bus.valid_out}, 64'd1);
    send(32'h99AABBCC, 4'b1100, 1'b1, 3'd2, w);
    settle_and_compare(tag);
  endtask

  initial begin
    int w;
    logic [2:0] cnt;
    int nn, pl, tot;
    logic [7:0] pb[$];
    logic [31:0] h, d;
    logic [3:0] k;

    rst = 1'b1;
    bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
    bus.byte_extract_cnt = '0;
    fork
      ready_gen();
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vout", {63'd0, bus.valid_out}, 64'd0);
    chk("rst_vhdr", {63'd0, bus.valid_header}, 64'd0);
    chk("rst_data", {32'd0, bus.data_out}, 64'd0);
    chk("rst_header", {32'd0, bus.header_out}, 64'd0);
    chk("rst_keeps", {56'd0, bus.keep_out, bus.keep_header}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_t1("t1");

    exp_hdr.push_back({4'b0001, 32'h00000011});
    exp_pay.push_back({1'b0, 4'b1111, 32'h22334455});
    exp_pay.push_back({1'b0, 4'b1111, 32'h66778899});
    exp_pay.push_back({1'b1, 4'b1100, 32'hAABB0000});
    send(32'h11223344, 4'b1111, 1'b0, 3'd1, w);
    send(32'h55667788, 4'b1111, 1'b0, 3'd1, w);
    send(32'h99AABBCC, 4'b1110, 1'b1, 3'd1, w);
    settle_and_compare("t2");

    exp_hdr.push_back({4'b0000, 32'h00000000});
    exp_pay.push_back({1'b0, 4'b1111, 32'hA0A1A2A3});
    exp_pay.push_back({1'b0, 4'b1111, 32'hB0B1B2B3});
    exp_pay.push_back({1'b1, 4'b1111, 32'hC0C1C2C3});
    send(32'hA0A1A2A3, 4'b1111, 1'b0, 3'd0, w);
    send(32'hB0B1B2B3, 4'b1111, 1'b0, 3'd0, w);
    send(32'hC0C1C2C3, 4'b1111, 1'b1, 3'd0, w);
    settle_and_compare("t3");

    exp_hdr.push_back({4'b1111, 32'h11223344});
    exp_hdr.push_back({4'b1111, 32'hCAFEBABE});
    send(32'h11223344, 4'b1111, 1'b1, 3'd4, w);
    send(32'hCAFEBABE, 4'b1111, 1'b1, 3'd7, w);
    chk("t4_b2b_wait", w, 0);
    settle_and_compare("t4");

    exp_hdr.push_back({4'b0110, 32'h00DEAD00});
    send(32'hDEAD0000, 4'b1100, 1'b1, 3'd3, w);
    chk("t5_short_pulse", {63'd0, bus.short_pkt}, 64'd1);
    @(posedge clk); #1;
    chk("t5_short_clear", {63'd0, bus.short_pkt}, 64'd0);
    settle_and_compare("t5");
    chk("t5_short_cnt", short_cnt, 1);

    exp_hdr.push_back({4'b0001, 32'h00000077});
    send(32'h77665544, 4'b1000, 1'b1, 3'd1, w);
    settle_and_compare("t6");
    chk("t6_short_cnt", short_cnt, 1);

    send(32'h11223344, 4'b1111, 1'b0, 3'd2, w);
    send(32'h55667788, 4'b1111, 1'b0, 3'd2, w);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_vout", {63'd0, bus.valid_out}, 64'd0);
    chk("rstmid_vhdr", {63'd0, bus.valid_header}, 64'd0);
    chk("rstmid_data", {27'd0, bus.last_out, bus.keep_out, bus.data_out}, 64'd0);
    chk("rstmid_header", {28'd0, bus.keep_header, bus.header_out}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    act_hdr.delete(); act_pay.delete();
    @(posedge clk); #1;
    run_t1("t7");

    rnd_on = 1;
    for (int p = 0; p < 20; p++) begin
      cnt = 3'($urandom_range(0, 7));
      nn = (cnt > 3'd4) ? 4 : int'(cnt);
      pl = $urandom_range(1, 12);
      tot = nn + pl;
      pb.delete();
      h = '0;
      for (int i = 0; i < tot; i++) pb.push_back(8'($urandom));
      for (int i = 0; i < nn; i++) h = {h[23:0], pb[i]};
      exp_hdr.push_back({4'((1 << nn) - 1), h});
      for (int b = nn; b < tot; b += 4) begin
        d = '0; k = '0;
        for (int j = 0; j < 4; j++)
          if (b + j < tot) begin d[31-8*j -: 8] = pb[b+j]; k[3-j] = 1'b1; end
        exp_pay.push_back({(b + 4 >= tot), k, d});
      end
      for (int b = 0; b < tot; b += 4) begin
        d = '0; k = '0;
        for (int j = 0; j < 4; j++)
          if (b + j < tot) begin d[31-8*j -: 8] = pb[b+j]; k[3-j] = 1'b1; end
        send(d, k, (b + 4 >= tot), (b == 0) ? cnt : 3'($urandom_range(0, 7)), w);
      end
    end
    rnd_on = 0;
    settle_and_compare("rnd");
    chk("rnd_short_cnt", short_cnt, 1);
    chk("hold_stable", hold_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
